// File: rtl/i281_dmem_uart_dump.sv
// Serialises a header byte followed by a snapshot of the i281 CPU's 16 data-memory
// bytes as back-to-back UART 8N1 frames on tx.
module i281_dmem_uart_dump #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] datamem0,
  input  logic [7:0] datamem1,
  input  logic [7:0] datamem2,
  input  logic [7:0] datamem3,
  input  logic [7:0] datamem4,
  input  logic [7:0] datamem5,
  input  logic [7:0] datamem6,
  input  logic [7:0] datamem7,
  input  logic [7:0] datamem8,
  input  logic [7:0] datamem9,
  input  logic [7:0] datamem10,
  input  logic [7:0] datamem11,
  input  logic [7:0] datamem12,
  input  logic [7:0] datamem13,
  input  logic [7:0] datamem14,
  input  logic [7:0] datamem15,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [4:0] frame_idx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA, STOP_BIT} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [4:0]    frame_reg, frame_next;
  logic          tx_reg, tx_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          accept;
  logic          bit_end;
  logic [2:0]    bit_inc;
  logic [3:0]    snap_sel;
  logic [7:0]    cur_byte;
  logic [7:0]    din [16];
  logic [7:0]    snap_reg [16];

  assign din[0]  = datamem0;
  assign din[1]  = datamem1;
  assign din[2]  = datamem2;
  assign din[3]  = datamem3;
  assign din[4]  = datamem4;
  assign din[5]  = datamem5;
  assign din[6]  = datamem6;
  assign din[7]  = datamem7;
  assign din[8]  = datamem8;
  assign din[9]  = datamem9;
  assign din[10] = datamem10;
  assign din[11] = datamem11;
  assign din[12] = datamem12;
  assign din[13] = datamem13;
  assign din[14] = datamem14;
  assign din[15] = datamem15;

  // Snapshot has no reset: it is always reloaded on the accepting edge before use.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_snap
      always_ff @(posedge clock) begin
        if (accept) snap_reg[gi] <= din[gi];
      end
    end
  endgenerate

  // Frame n carries snapshot byte n-1; the 4-bit subtract maps frame 16 onto byte 15.
  assign snap_sel = frame_reg[3:0] - 4'd1;
  assign cur_byte = (frame_reg == 5'd0) ? HEADER : snap_reg[snap_sel];
  assign bit_end  = (cnt_reg == '0);
  assign bit_inc  = bit_reg + 3'd1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = bit_end ? RELOAD : cnt_reg - CW'(1);
    bit_next   = bit_reg;
    frame_next = frame_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next   = '0;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        frame_next = 5'd0;
        if (start) begin
          accept     = 1'b1;
          state_next = START_BIT;
          cnt_next   = RELOAD;
          bit_next   = 3'd0;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          state_next = DATA;
          bit_next   = 3'd0;
          tx_next    = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_reg == 3'd7) begin
            state_next = STOP_BIT;
            tx_next    = 1'b1;
          end else begin
            bit_next = bit_inc;
            tx_next  = cur_byte[bit_inc];
          end
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          if (frame_reg == 5'd16) begin
            state_next = IDLE;
            cnt_next   = '0;
            frame_next = 5'd0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            tx_next    = 1'b1;
          end else begin
            state_next = START_BIT;
            frame_next = frame_reg + 5'd1;
            tx_next    = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= 3'd0;
      frame_reg <= 5'd0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      frame_reg <= frame_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign tx        = tx_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign frame_idx = frame_reg;

endmodule

// File: tb/tb_i281_dmem_uart_dump.sv
// Self-checking bench: expected tx/busy/frame_idx waveforms come from frame/bit arithmetic
// over the byte list, and a mid-bit UART sampler decodes each frame for comparison.
module tb_i281_dmem_uart_dump;

  localparam int         CPB = 4;
  localparam logic [7:0] HDR = 8'hA5;
  localparam int         DUMP_CYCLES = 170 * CPB;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] dm [16];
  logic       tx;
  logic       busy;
  logic       done;
  logic [4:0] frame_idx;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_bytes [17];

  i281_dmem_uart_dump #(.CLKS_PER_BIT(CPB), .HEADER(HDR)) dut (
    .clock(clock), .reset(reset), .start(start),
    .datamem0(dm[0]),   .datamem1(dm[1]),   .datamem2(dm[2]),   .datamem3(dm[3]),
    .datamem4(dm[4]),   .datamem5(dm[5]),   .datamem6(dm[6]),   .datamem7(dm[7]),
    .datamem8(dm[8]),   .datamem9(dm[9]),   .datamem10(dm[10]), .datamem11(dm[11]),
    .datamem12(dm[12]), .datamem13(dm[13]), .datamem14(dm[14]), .datamem15(dm[15]),
    .tx(tx), .busy(busy), .done(done), .frame_idx(frame_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 16; i++) dm[i] = 8'($urandom);
  endtask

  // Accept a dump from IDLE and follow it cycle by cycle to its done pulse.
  task automatic run_dump(input string name, input bit glitch, input bit hold);
    int busy_cycles;
    bit bad;
    logic [7:0] rx;
    exp_bytes[0] = HDR;
    for (int i = 0; i < 16; i++) exp_bytes[i+1] = dm[i];
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    busy_cycles = 0;
    bad = 1'b0;
    rx = 8'h00;
    for (int k = 0; k < DUMP_CYCLES; k++) begin
      int f;
      int p;
      logic etx;
      f = k / (10 * CPB);
      p = (k % (10 * CPB)) / CPB;
      if (p == 0) etx = 1'b0;
      else if (p == 9) etx = 1'b1;
      else etx = exp_bytes[f][p-1];
      if (busy) busy_cycles++;
      if (p >= 1 && p <= 8 && (k % CPB) == CPB / 2) rx[p-1] = tx;
      if (!bad) begin
        checks++;
        if ({tx, busy, frame_idx, done} !== {etx, 1'b1, 5'(f), 1'b0}) begin
          errors++;
          bad = 1'b1;
          $display("FAIL %s wave cycle %0d: tx/busy/frame_idx/done=%b/%b/%0d/%b required %b/1/%0d/0",
                   name, k, tx, busy, frame_idx, done, etx, f);
        end
      end
      if (p == 9 && (k % CPB) == CPB - 1) begin
        checks++;
        if (rx !== exp_bytes[f]) begin
          errors++;
          $display("FAIL %s byte frame %0d: decoded %h required %h", name, f, rx, exp_bytes[f]);
        end
      end
      if (glitch && k == 300) begin
        for (int i = 0; i < 16; i++) dm[i] = 8'hEE;
        start = 1'b1;
      end
      if (glitch && k == 304) start = 1'b0;
      step();
    end
    checks++;
    if ({tx, busy, frame_idx, done} !== {1'b1, 1'b0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL %s done cycle: tx/busy/frame_idx/done=%b/%b/%0d/%b required 1/0/0/1",
               name, tx, busy, frame_idx, done);
    end
    checks++;
    if (busy_cycles !== DUMP_CYCLES) begin
      errors++;
      $display("FAIL %s busy length: %0d cycles required %0d", name, busy_cycles, DUMP_CYCLES);
    end
    $display("dump %s: header %h first %h last %h busy %0d cycles", name,
             exp_bytes[0], exp_bytes[1], exp_bytes[16], busy_cycles);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    randomize_mem();
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if ({tx, busy, frame_idx, done} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
        errors++;
        $display("FAIL reset idle cycle %0d: tx/busy/frame_idx/done=%b/%b/%0d/%b required 1/0/0/0",
                 c, tx, busy, frame_idx, done);
      end
    end
    $display("reset: idle checked for 10 cycles");
  endtask

  task automatic test_header();
    randomize_mem();
    dm[0] = 8'h3C;
    run_dump("header_3c", 1'b0, 1'b0);
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < 16; i++) dm[i] = 8'(i * 17);
    run_dump("ramp_11", 1'b0, 1'b0);
  endtask

  task automatic test_snapshot();
    randomize_mem();
    run_dump("snapshot_glitch", 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int seen;
    logic [7:0] b4;
    randomize_mem();
    b4 = dm[4];
    start = 1'b1;
    step();
    start = 1'b0;
    // Cycle 217 sits inside data bit 3 of frame 5.
    for (int k = 0; k < 217; k++) step();
    checks++;
    if ({frame_idx, tx} !== {5'd5, b4[3]}) begin
      errors++;
      $display("FAIL reset_mid position: frame_idx/tx=%0d/%b required 5/%b", frame_idx, tx, b4[3]);
    end
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if ({tx, busy, frame_idx, done} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid abort: tx/busy/frame_idx/done=%b/%b/%0d/%b required 1/0/0/0",
               tx, busy, frame_idx, done);
    end
    seen = 0;
    for (int k = 0; k < DUMP_CYCLES; k++) begin
      step();
      if (done || busy || !tx) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid quiet: %0d active cycles required 0", seen);
    end
    $display("reset_mid: aborted at frame 5 bit 3, %0d active cycles after", seen);
  endtask

  task automatic test_back_to_back();
    randomize_mem();
    run_dump("b2b_first", 1'b0, 1'b1);
    run_dump("b2b_second", 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) dm[i] = 8'h00;
    test_reset();
    test_header();
    test_full_dump();
    test_snapshot();
    test_reset_mid();
    test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      randomize_mem();
      run_dump("random", 1'b0, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i281_dmem_uart_dump.md
I281_DMEM_UART_DUMP -- requirements
Module: i281_dmem_uart_dump

Interface
- REQ-001: Parameter CLKS_PER_BIT, default 434, SHALL set clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- REQ-002: Parameter HEADER, default 8'hA5, SHALL set the sync byte sent before the memory bytes.
- REQ-003: clock  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-004: reset  input  1  SHALL be synchronous, active-high reset.
- REQ-005: start  input  1  SHALL request a dump; level-sampled on each rising edge.
- REQ-006: datamem0..datamem15  input  8 each  SHALL be the 16 data-memory bytes, the CPU's datamem outputs.
- REQ-007: tx  output  1  SHALL be the UART 8N1 serial line, idle high.
- REQ-008: busy  output  1  SHALL be high while a dump is in progress.
- REQ-009: done  output  1  SHALL be a one-cycle pulse at dump completion.
- REQ-010: frame_idx  output  5  SHALL give the frame being sent: 0 = HEADER, n = datamem(n-1), n = 1..16.

Function
- REQ-011: All outputs SHALL be registered.
- REQ-012: States SHALL be IDLE, START_BIT, DATA, STOP_BIT.
- REQ-013: In IDLE, start=1 at an edge SHALL accept the dump and move to START_BIT.
- REQ-014: On the accepting edge, all 16 datamem inputs SHALL be snapshotted. Input changes after that edge SHALL NOT affect the dump.
- REQ-015: start SHALL be ignored in every state except IDLE.
- REQ-016: Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at each bit boundary.
- REQ-017: Frame format SHALL be: tx=0 start bit, 8 data bits LSB first, tx=1 stop bit.
- REQ-018: Frames SHALL be sent back to back with no idle gap: HEADER, then snapshot bytes 0..15. This gives 17 frames = 170*CLKS_PER_BIT cycles.
- REQ-019: STOP_BIT end with frame_idx<16 SHALL increment frame_idx and go to START_BIT.
- REQ-020: STOP_BIT end with frame_idx=16 SHALL go to IDLE, drop busy and pulse done in that same cycle.
- REQ-021: busy and tx=0 SHALL both assert in the first cycle after the accepting edge.
- REQ-022: start=1 in the done cycle SHALL be accepted, since the state is IDLE. A new dump then begins with no gap.
- REQ-023: In IDLE, tx SHALL be 1 and frame_idx SHALL be 0.
- REQ-024: The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never wrap during a bit.
- REQ-025: The data bit index SHALL be 3 bits wide. A frame's 8 data bits SHALL end on bit index 7.

Reset
- REQ-026: reset=1 at an edge SHALL force IDLE, tx=1, busy=0, done=0, frame_idx=0 and all counters to 0, from any state.
- REQ-027: Reset asserted mid-frame SHALL abort the dump with tx=1 on the next cycle; no done pulse SHALL be issued.
- REQ-028: reset SHALL take priority over a simultaneous start.
- REQ-029: The snapshot register contents after reset SHALL be don't-care; they are always reloaded before use.

Verification (CLKS_PER_BIT=4, HEADER=8'hA5)
- REQ-030: Reset for 2 cycles, then idle for 10 cycles -> tx=1, busy=0, done=0, frame_idx=0 throughout.
- REQ-031: Pulse start for 1 cycle with datamem0=8'h3C -> tx=0 for 4 cycles, then header bits 1,0,1,0,0,1,0,1 at 4 cycles each, then tx=1 for 4 cycles. Next comes frame_idx=1 with bits 0,0,1,1,1,1,0,0.
- REQ-032: Full dump with datamem(n)=n*8'h11 -> busy high for exactly 680 cycles. The decoded byte stream is A5,00,11,...,FF. done is high for 1 cycle as busy falls.
- REQ-033: Mid-dump, set all datamem inputs to 8'hEE and pulse start again -> the byte stream is unchanged and the dump length stays 680 cycles.
- REQ-034: Assert reset during frame_idx=5, data bit 3 -> the next cycle shows tx=1, busy=0, frame_idx=0, and done never pulses.
- REQ-035: Hold start=1 continuously -> the second dump's start bit begins in the cycle right after done, with no idle gap.
